// File: rtl/dmem_responder_pkg.sv
// Purpose: shared encodings and the request error check for the slow data-memory responder.
// Latency: n/a (types, constants and a pure combinational function only).
// Backpressure: n/a.
// Contents: dtype_e (access size), state_e (responder FSM), req_err() (accept-time legality check).
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DT_BYTE = 2'b00,
        DT_HALF = 2'b01,
        DT_WORD = 2'b10,
        DT_ILL  = 2'b11
    } dtype_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // A request is rejected when its type is illegal, its address is not
    // naturally aligned for the access size, or its word index is past the array.
    function automatic logic req_err(input logic [1:0] dtype,
                                     input logic [1:0] off,
                                     input logic       idx_oob);
        logic e;
        case (dtype)
            DT_BYTE: e = 1'b0;
            DT_HALF: e = off[0];
            DT_WORD: e = |off;
            default: e = 1'b1;
        endcase
        return e | idx_oob;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Purpose: request/response bundle between a load/store requester and dmem_responder.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
// Ports: master = requester side, slave = memory responder side.
interface dmem_responder_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_type;
    logic              req_unsigned;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_type, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_type, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_unit.sv
// Purpose: big-endian lane extract/extend for loads and lane merge for sub-word stores.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: off/dtype/is_unsigned select the lane, old_word is the stored word,
//        wdata is right-aligned store data; load_data and merged_word are the results.
module dmem_lane_unit
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  dtype,
    input  logic        is_unsigned,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // Byte offset 0 is the most significant byte of the word.
        byte_lane = 8'h00;
        case (off)
            2'd0:    byte_lane = old_word[31:24];
            2'd1:    byte_lane = old_word[23:16];
            2'd2:    byte_lane = old_word[15:8];
            default: byte_lane = old_word[7:0];
        endcase
        half_lane = off[1] ? old_word[15:0] : old_word[31:16];

        load_data   = old_word;
        merged_word = old_word;
        case (dtype)
            DT_BYTE: begin
                load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
                case (off)
                    2'd0:    merged_word[31:24] = wdata[7:0];
                    2'd1:    merged_word[23:16] = wdata[7:0];
                    2'd2:    merged_word[15:8]  = wdata[7:0];
                    default: merged_word[7:0]   = wdata[7:0];
                endcase
            end
            DT_HALF: begin
                load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
                if (off[1]) begin
                    merged_word[15:0] = wdata[15:0];
                end else begin
                    merged_word[31:16] = wdata[15:0];
                end
            end
            default: begin
                load_data   = old_word;
                merged_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: single-outstanding data-memory responder with configurable wait states over a word array.
// Latency: accept in N -> rsp_valid in N+WAIT_CYCLES+2 (N+1 for rejected requests).
// Backpressure: req_ready only in IDLE; response held stable until rsp_valid && rsp_ready.
// Ports: clk, rst (async, active-high); bus = slave side of dmem_responder_if.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT  = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [IDX_W:0]   DEPTH_LIM = (IDX_W + 1)'(DEPTH_WORDS);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;

    logic              lat_write;
    logic [1:0]        lat_off;
    logic [MEM_AW-1:0] lat_idx;
    logic [31:0]       lat_wdata;
    logic [1:0]        lat_type;
    logic              lat_unsigned;

    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  req_idx;
    logic              req_oob;
    logic              accept;
    logic              accept_err;
    logic [31:0]       old_word;
    logic [31:0]       load_data;
    logic [31:0]       merged_word;

    assign req_idx    = bus.req_addr[ADDR_W-1:2];
    assign req_oob    = ({1'b0, req_idx} >= DEPTH_LIM);
    assign accept     = bus.req_valid && bus.req_ready;
    assign accept_err = req_err(bus.req_type, bus.req_addr[1:0], req_oob);

    // Ready is gated by rst so it stays low for the whole reset pulse.
    assign bus.req_ready = (state_q == ST_IDLE) && !rst;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign old_word = mem[lat_idx];

    dmem_lane_unit u_lane (
        .off         (lat_off),
        .dtype       (lat_type),
        .is_unsigned (lat_unsigned),
        .old_word    (old_word),
        .wdata       (lat_wdata),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (accept_err) begin
                        state_d = ST_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT:   if (cnt_q == '0) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            lat_write    <= 1'b0;
            lat_off      <= '0;
            lat_idx      <= '0;
            lat_wdata    <= '0;
            lat_type     <= '0;
            lat_unsigned <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lat_write    <= bus.req_write;
                lat_off      <= bus.req_addr[1:0];
                lat_idx      <= req_idx[MEM_AW-1:0];
                lat_wdata    <= bus.req_wdata;
                lat_type     <= bus.req_type;
                lat_unsigned <= bus.req_unsigned;
                cnt_q        <= CNT_INIT;
                // Rejected requests skip the array entirely; their response is final here.
                if (accept_err) begin
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b1;
                end
            end
            if (state_q == ST_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == ST_ACCESS) begin
                rsp_rdata_q <= lat_write ? 32'h0 : load_data;
                rsp_err_q   <= 1'b0;
            end
        end
    end

    // The array is not reset; a reset before the ACCESS edge leaves state_q
    // out of ACCESS, so an in-flight store never lands.
    always_ff @(posedge clk) begin
        if (state_q == ST_ACCESS && lat_write) begin
            mem[lat_idx] <= merged_word;
        end
    end

endmodule
